// File: rtl/round_sched.sv
// round_sched: sequences one block through NUM_ROUNDS passes of a shared stage datapath
module round_sched #(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              stage_valid_o,
    output logic [DATA_W-1:0] stage_data_o,
    output logic [3:0]        stage_num_o,
    output logic              last_stage_o,
    input  logic              stage_valid_i,
    input  logic [DATA_W-1:0] stage_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

    state_t              state_q, state_d;
    logic [3:0]          round_q, round_d;
    logic [DATA_W-1:0]   blk_q, blk_d;

    // Outputs decode straight from registered state; only in_ready reacts to flush/rst
    assign in_ready_o    = (state_q == IDLE) && !flush_i && !rst;
    assign stage_valid_o = state_q == ISSUE;
    assign stage_data_o  = blk_q;
    assign stage_num_o   = round_q;
    assign last_stage_o  = round_q == LAST;
    assign out_valid_o   = state_q == DONE;
    assign data_o        = blk_q;
    assign busy_o        = state_q != IDLE;

    // Next-state logic: flush overrides everything, round returns to 0 whenever we go idle
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;
        if (flush_i) begin
            state_d = IDLE;
            round_d = '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i && in_ready_o) begin
                    blk_d   = data_i;
                    round_d = '0;
                    state_d = ISSUE;
                end
                ISSUE: state_d = WAIT;
                WAIT: if (stage_valid_i) begin
                    blk_d = stage_data_i;
                    if (round_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = ISSUE;
                    end
                end
                DONE: if (out_ready_i) begin
                    state_d = IDLE;
                    round_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, round counter and block register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
        end
    end
endmodule

// File: tb/tb_round_sched.sv
// tb_round_sched: randomized directed bench for round_sched with a stub stage and result model
module tb_round_sched;
    localparam int N = 10;
    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst, in_valid_i, flush_i, stage_valid_i, out_ready_i;
    logic [W-1:0] data_i, stage_data_i, stage_data_o, data_o;
    logic         in_ready_o, stage_valid_o, last_stage_o, out_valid_o, busy_o;
    logic [3:0]   stage_num_o;
    logic [W-1:0] last_out;
    int           tests = 0;
    int           fails = 0;

    round_sched #(.NUM_ROUNDS(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_i(data_i), .flush_i(flush_i), .stage_valid_o(stage_valid_o),
        .stage_data_o(stage_data_o), .stage_num_o(stage_num_o), .last_stage_o(last_stage_o),
        .stage_valid_i(stage_valid_i), .stage_data_i(stage_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .data_o(data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {8{$urandom}};
    endfunction

    // Stub stage transform: mode 0 increments, mode 1 rotates left and mixes in the round index
    function automatic logic [W-1:0] stub_f(input logic [W-1:0] d, input int r, input int mode);
        return (mode == 0) ? d + W'(1) : ({d[W-2:0], d[W-1]} ^ W'(r * 37 + 1));
    endfunction

    // Expected final block: the stage transform composed over all rounds
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input int mode);
        logic [W-1:0] x;
        if (mode == 0) return d + W'(N);
        x = d;
        for (int r = 0; r < N; r++) x = stub_f(x, r, mode);
        return x;
    endfunction

    // abort_kind: 0 none, 1 flush+response in WAIT of abort_round, 2 rst in abort_round, 3 flush in DONE
    task automatic run_block(input logic [W-1:0] d, input int mode, input int rand_lat,
                             input int hold, input int abort_round, input int abort_kind);
        logic [W-1:0] op, resp, exp_out;
        int cyc, exp_cyc, lat;
        exp_out = ref_result(d, mode);
        in_valid_i = 1'b1;
        data_i = d;
        #1;
        chk1("in_ready_idle", in_ready_o, 1'b1);
        tick();
        in_valid_i = 1'b0;
        cyc = 0;
        exp_cyc = 0;
        for (int r = 0; r < N; r++) begin
            chk1("issue_strobe", stage_valid_o, 1'b1);
            chk("stage_num", W'(stage_num_o), W'(r));
            chk1("last_stage", last_stage_o, r == N - 1);
            chk1("in_ready_busy", in_ready_o, 1'b0);
            op = stage_data_o;
            resp = stub_f(op, r, mode);
            lat = (rand_lat == 0) ? 2 : ((r % 2 == 0) ? 1 : int'($urandom_range(1, 5)));
            exp_cyc += lat + 1;
            tick();
            cyc++;
            for (int w = 1; w <= lat; w++) begin
                chk1("strobe_one_cycle", stage_valid_o, 1'b0);
                chk1("out_valid_early", out_valid_o, 1'b0);
                chk("num_stable", W'(stage_num_o), W'(r));
                if (r == abort_round && w == 1 && abort_kind == 1) begin
                    flush_i = 1'b1;
                    stage_valid_i = 1'b1;
                    stage_data_i = resp;
                    tick();
                    flush_i = 1'b0;
                    stage_valid_i = 1'b0;
                    #1;
                    chk1("flush_idle", busy_o, 1'b0);
                    chk1("flush_ready", in_ready_o, 1'b1);
                    chk1("flush_no_out", out_valid_o, 1'b0);
                    chk("flush_round", W'(stage_num_o), W'(0));
                    chk("flush_data_kept", data_o, op);
                    last_out = op;
                    return;
                end
                if (r == abort_round && w == 1 && abort_kind == 2) begin
                    rst = 1'b1;
                    #1;
                    chk1("rst_stage_valid", stage_valid_o, 1'b0);
                    chk1("rst_out_valid", out_valid_o, 1'b0);
                    chk1("rst_busy", busy_o, 1'b0);
                    chk("rst_data", data_o, W'(0));
                    chk("rst_num", W'(stage_num_o), W'(0));
                    chk1("rst_last", last_stage_o, 1'b0);
                    chk1("rst_ready", in_ready_o, 1'b0);
                    tick();
                    rst = 1'b0;
                    stage_valid_i = 1'b1;
                    stage_data_i = resp;
                    #1;
                    chk1("rel_ready", in_ready_o, 1'b1);
                    tick();
                    stage_valid_i = 1'b0;
                    chk1("late_resp_busy", busy_o, 1'b0);
                    chk("late_resp_data", data_o, W'(0));
                    chk1("late_resp_strobe", stage_valid_o, 1'b0);
                    last_out = '0;
                    return;
                end
                if (w == lat) begin
                    stage_valid_i = 1'b1;
                    stage_data_i = resp;
                end
                tick();
                cyc++;
                stage_valid_i = 1'b0;
            end
        end
        chk1("out_valid", out_valid_o, 1'b1);
        chk("latency", W'(cyc), W'(exp_cyc));
        chk("result", data_o, exp_out);
        for (int h = 0; h < hold; h++) begin
            stage_valid_i = 1'b1;
            stage_data_i = rnd();
            tick();
            chk1("hold_valid", out_valid_o, 1'b1);
            chk("hold_data", data_o, exp_out);
            chk1("hold_ready", in_ready_o, 1'b0);
        end
        stage_valid_i = 1'b0;
        last_out = exp_out;
        if (abort_kind == 3) begin
            flush_i = 1'b1;
            out_ready_i = 1'b1;
            #1;
            chk1("flush_done_ready", in_ready_o, 1'b0);
            tick();
            flush_i = 1'b0;
            out_ready_i = 1'b0;
            chk1("flush_done_idle", busy_o, 1'b0);
            chk1("flush_done_out", out_valid_o, 1'b0);
            return;
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk1("hs_idle", busy_o, 1'b0);
        chk1("hs_out_low", out_valid_o, 1'b0);
        chk1("hs_ready", in_ready_o, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        stage_valid_i = 1'b0;
        out_ready_i = 1'b0;
        data_i = '0;
        stage_data_i = '0;
        last_out = '0;
        tick();
        tick();
        chk1("reset_ready", in_ready_o, 1'b0);
        chk1("reset_busy", busy_o, 1'b0);
        chk1("reset_strobe", stage_valid_o, 1'b0);
        chk1("reset_out", out_valid_o, 1'b0);
        chk("reset_data", data_o, W'(0));
        chk("reset_num", W'(stage_num_o), W'(0));
        chk1("reset_last", last_stage_o, 1'b0);
        rst = 1'b0;
        #1;
        chk1("release_ready", in_ready_o, 1'b1);

        run_block(W'(0), 0, 0, 0, -1, 0);
        chk("inc_result", last_out, W'('hA));

        stage_valid_i = 1'b1;
        stage_data_i = rnd();
        tick();
        stage_valid_i = 1'b0;
        chk1("spurious_idle_busy", busy_o, 1'b0);
        chk("spurious_idle_data", data_o, last_out);

        run_block(W'(0), 0, 1, 0, -1, 0);
        run_block(rnd(), 1, 0, 7, -1, 0);
        run_block(rnd(), 1, 0, 0, 4, 1);
        run_block(W'(5), 0, 0, 0, -1, 0);
        chk("after_flush_result", last_out, W'('hF));
        run_block(rnd(), 1, 1, 0, 6, 2);
        run_block(rnd(), 1, 1, 2, -1, 3);
        for (int i = 0; i < 6; i++)
            run_block(rnd(), int'($urandom_range(0, 1)), 1, int'($urandom_range(0, 3)), -1, 0);

        flush_i = 1'b1;
        in_valid_i = 1'b1;
        data_i = rnd();
        #1;
        chk1("flush_idle_ready", in_ready_o, 1'b0);
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk1("flush_idle_noaccept", busy_o, 1'b0);
        chk("flush_idle_data", data_o, last_out);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
